mux_arbiter: RTL

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
// Round-robin arbiter that grants one of four requesters (A..D) ownership
// of a shared 4-bit path. Each owner keeps the grant for at most four
// cycles. On release the start pointer advances past the owner, and the
// next owner is chosen at the same edge, so there is no idle gap.
module mux_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] REQ,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    output logic [3:0] GNT,
    output logic [1:0] SEL,
    output logic [3:0] SAIDA,
    output logic       VALID
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] BURST_LAST = 2'd3;

    state_t     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [1:0] cnt_q,   cnt_d;

    // Round-robin scan: the first set request bit, starting at ptr and wrapping.
    // The result is {found, index}.
    function automatic logic [2:0] arbitrate(input logic [3:0] req,
                                             input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    logic [2:0] arb_idle;
    logic [2:0] arb_release;
    logic [1:0] ptr_next;

    // Arbitration results: one from the current pointer (IDLE grant) and one
    // from the pointer just past the owner (same-edge re-grant on release).
    always_comb begin
        ptr_next    = sel_q + 2'd1;
        arb_idle    = arbitrate(REQ, ptr_q);
        arb_release = arbitrate(REQ, ptr_next);
    end

    // Next-state logic for the IDLE/BUSY controller and its registered outputs.
    always_comb begin
        // NOTE: every signal gets a default here so that no path through the
        // case statement leaves it unassigned, which would infer a latch.
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                // The pointer is left unchanged. Only a release moves it.
                if (arb_idle[2]) begin
                    state_d = BUSY;
                    sel_d   = arb_idle[1:0];
                    gnt_d   = 4'b0001 << arb_idle[1:0];
                    cnt_d   = 2'd0;
                end
            end
            BUSY: begin
                if (REQ[sel_q] && (cnt_q < BURST_LAST)) begin
                    cnt_d = cnt_q + 2'd1;
                end else begin
                    // Release. The old owner is scanned last, so it wins
                    // again only if no other requester is asking.
                    ptr_d = ptr_next;
                    cnt_d = 2'd0;
                    if (arb_release[2]) begin
                        state_d = BUSY;
                        sel_d   = arb_release[1:0];
                        gnt_d   = 4'b0001 << arb_release[1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State and output registers. Reset has priority and aborts any burst
    // without advancing the pointer.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments, so every flop samples
        // the pre-edge values no matter what order the statements are in.
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shared data path: an unregistered mux, so data changes reach SAIDA
    // in the same cycle. It is forced to zero while IDLE.
    always_comb begin
        SAIDA = 4'b0000;
        if (state_q == BUSY) begin
            unique case (sel_q)
                2'd0:    SAIDA = A;
                2'd1:    SAIDA = B;
                2'd2:    SAIDA = C;
                default: SAIDA = D;
            endcase
        end
    end

    assign GNT   = gnt_q;
    assign SEL   = sel_q;
    assign VALID = (state_q == BUSY);

endmodule
